// File: rtl/set_bit_pkg.sv
//------------------------------------------------------------------------------
// Module : set_bit_pkg
// Brief  : Shared state encoding and default width for the set-bit serializer.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package set_bit_pkg;

    localparam int C_DEFAULT_WIDTH = 12;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage : set_bit_pkg

`default_nettype wire

// File: rtl/set_bit_serializer_bit_pick.sv
//------------------------------------------------------------------------------
// Module : bit_pick
// Brief  : Purely combinational selection of the lowest/highest set bit of a word.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bit_pick
    import set_bit_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_word,
    input  logic             i_dir,
    output logic [WIDTH-1:0] o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_single
);

    logic             w_found;
    logic [IDX_W-1:0] w_idx;
    logic             w_nonzero;

    // dir=1 lets the highest set bit win by overwriting; dir=0 locks on the first hit
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_word[i]) begin
                if (i_dir) begin
                    w_idx = IDX_W'(i);
                end else if (!w_found) begin
                    w_idx   = IDX_W'(i);
                    w_found = 1'b1;
                end
            end
        end
    end

    assign w_nonzero = |i_word;
    assign o_idx     = w_idx;
    assign o_onehot  = w_nonzero ? ({{(WIDTH-1){1'b0}}, 1'b1} << w_idx) : '0;
    assign o_single  = w_nonzero && ((i_word & (i_word - WIDTH'(1))) == '0);

endmodule : bit_pick

`default_nettype wire

// File: rtl/set_bit_serializer.sv
//------------------------------------------------------------------------------
// Module : set_bit_serializer
// Brief  : Emits one beat per set bit of an accepted word, in LSB- or MSB-first order.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module set_bit_serializer
    import set_bit_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             dir_i,
    input  logic             data_val_i,
    output logic             data_rdy_o,
    output logic [WIDTH-1:0] bit_onehot_o,
    output logic [IDX_W-1:0] bit_idx_o,
    output logic             bit_last_o,
    output logic             bit_val_o,
    input  logic             bit_rdy_i
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_work;
    logic             r_dir;
    logic             r_rdy;

    logic [WIDTH-1:0] w_onehot;
    logic [IDX_W-1:0] w_idx;
    logic             w_single;
    logic             w_accept;
    logic             w_val;
    logic             w_hs;

    bit_pick #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_bit_pick (
        .i_word   (r_work),
        .i_dir    (r_dir),
        .o_onehot (w_onehot),
        .o_idx    (w_idx),
        .o_single (w_single)
    );

    assign w_val    = (r_state == ST_BUSY);
    assign w_accept = data_val_i & r_rdy;
    assign w_hs     = w_val & bit_rdy_i;

    // State register plus the working word it owns
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state <= ST_IDLE;
            r_work  <= '0;
            r_dir   <= 1'b0;
            r_rdy   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rdy   <= (w_state_nxt == ST_IDLE);
            if (w_accept) begin
                r_work <= data_i;
                r_dir  <= dir_i;
            end else if (w_hs) begin
                r_work <= r_work & ~w_onehot;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept && (data_i != '0)) w_state_nxt = ST_BUSY;
            ST_BUSY: if (w_hs && w_single)           w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        data_rdy_o   = r_rdy;
        bit_val_o    = w_val;
        bit_onehot_o = w_val ? w_onehot : '0;
        bit_idx_o    = w_val ? w_idx    : '0;
        bit_last_o   = w_val & w_single;
    end

endmodule : set_bit_serializer

`default_nettype wire
